// File: rtl/delay_step_accumulator.sv
// Per-element error/delay accumulator, one element per cycle.
// Publishes updated sample delays to the sample-select stage.
module delay_step_accumulator #(
  parameter int NUM_ELEMENTS     = 64,
  parameter int DW_TERM          = 21,
  parameter int DW_TERM_FRACTION = 4,
  parameter int DW_ERR           = DW_TERM + 2,
  parameter int DW_DELAY         = 12,
  parameter int STEP_Q           = 2 << DW_TERM_FRACTION
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [DW_DELAY-1:0]                    init_delay,
  input  logic [NUM_ELEMENTS-1:0][DW_TERM-1:0]   terms_in,
  input  logic                                   terms_ready,
  input  logic                                   final_scanpoint_in,
  output logic                                   terms_ack,
  output logic [NUM_ELEMENTS-1:0][DW_DELAY-1:0]  delay_out,
  output logic                                   delays_valid,
  input  logic                                   delays_ack,
  output logic                                   last_point,
  output logic                                   busy
);

  localparam int IW = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int SW = DW_ERR + 1;
  localparam logic signed [DW_ERR-1:0] ERR_MIN =
    {1'b1, {(DW_ERR-1){1'b0}}};
  localparam logic signed [DW_ERR-1:0] ERR_MAX =
    {1'b0, {(DW_ERR-1){1'b1}}};
  localparam logic [DW_DELAY-1:0] DLY_MAX = '1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_ELEMENTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TERMS,
    PROCESS,
    OUTPUT
  } state_t;

  state_t state_q, state_d;

  logic signed [DW_ERR-1:0]  err_q   [NUM_ELEMENTS];
  logic signed [DW_ERR-1:0]  err_d   [NUM_ELEMENTS];
  logic        [DW_DELAY-1:0] delay_q [NUM_ELEMENTS];
  logic        [DW_DELAY-1:0] delay_d [NUM_ELEMENTS];
  logic signed [DW_TERM-1:0] term_q  [NUM_ELEMENTS];
  logic signed [DW_TERM-1:0] term_d  [NUM_ELEMENTS];

  logic [IW-1:0] idx_q, idx_d;
  logic          final_q, final_d;
  logic          tack_q, tack_d;
  logic          valid_q, valid_d;

  logic signed [SW-1:0]       sum;
  logic signed [SW-1:0]       stepped;
  logic                       step2;
  logic signed [DW_ERR-1:0]   err_nxt;
  logic        [1:0]          dinc;
  logic        [DW_DELAY:0]   dsum;
  logic        [DW_DELAY-1:0] delay_nxt;

  // Datapath for the element currently selected by idx.
  always_comb begin
    sum     = SW'(err_q[idx_q]) + SW'(term_q[idx_q]);
    step2   = ~sum[SW-1];
    stepped = step2 ? (sum - SW'(STEP_Q)) : sum;
    if (stepped[SW-1] != stepped[SW-2]) begin
      err_nxt = stepped[SW-1] ? ERR_MIN : ERR_MAX;
    end else begin
      err_nxt = stepped[DW_ERR-1:0];
    end
    dinc = step2 ? 2'd2 : 2'd1;
    dsum = {1'b0, delay_q[idx_q]}
         + {{(DW_DELAY-1){1'b0}}, dinc};
    delay_nxt = dsum[DW_DELAY] ? DLY_MAX : dsum[DW_DELAY-1:0];
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    delay_d = delay_q;
    term_d  = term_q;
    idx_d   = idx_q;
    final_d = final_q;
    tack_d  = 1'b0;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_ELEMENTS; i++) begin
            err_d[i]   = '0;
            delay_d[i] = init_delay;
          end
          state_d = WAIT_TERMS;
        end
      end
      WAIT_TERMS: begin
        if (terms_ready) begin
          for (int i = 0; i < NUM_ELEMENTS; i++) begin
            term_d[i] = terms_in[i];
          end
          final_d = final_scanpoint_in;
          idx_d   = '0;
          tack_d  = 1'b1;
          state_d = PROCESS;
        end
      end
      PROCESS: begin
        err_d[idx_q]   = err_nxt;
        delay_d[idx_q] = delay_nxt;
        idx_d          = idx_q + IW'(1);
        if (idx_q == IDX_LAST) begin
          state_d = OUTPUT;
        end
      end
      OUTPUT: begin
        // valid rises one cycle after entry; ack only counts once visible
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (delays_ack) begin
          valid_d = 1'b0;
          state_d = final_q ? IDLE : WAIT_TERMS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      final_q <= 1'b0;
      tack_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        err_q[i]   <= '0;
        delay_q[i] <= '0;
        term_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      final_q <= final_d;
      tack_q  <= tack_d;
      valid_q <= valid_d;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        err_q[i]   <= err_d[i];
        delay_q[i] <= delay_d[i];
        term_q[i]  <= term_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      delay_out[i] = delay_q[i];
    end
  end

  assign terms_ack    = tack_q;
  assign delays_valid = valid_q;
  assign last_point   = valid_q & final_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_delay_step_accumulator.sv
// Directed bench for delay_step_accumulator (4 elements).
// Expected delays are hand-derived from the step rule.
module tb_delay_step_accumulator;

  localparam int N  = 4;
  localparam int TW = 21;
  localparam int DW = 12;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [DW-1:0]          init_delay;
  logic [N-1:0][TW-1:0]   terms_in;
  logic                   terms_ready;
  logic                   final_scanpoint_in;
  logic                   terms_ack;
  logic [N-1:0][DW-1:0]   delay_out;
  logic                   delays_valid;
  logic                   delays_ack;
  logic                   last_point;
  logic                   busy;

  int n_checks = 0;
  int n_errors = 0;

  delay_step_accumulator #(.NUM_ELEMENTS(N)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .init_delay         (init_delay),
    .terms_in           (terms_in),
    .terms_ready        (terms_ready),
    .final_scanpoint_in (final_scanpoint_in),
    .terms_ack          (terms_ack),
    .delay_out          (delay_out),
    .delays_valid       (delays_valid),
    .delays_ack         (delays_ack),
    .last_point         (last_point),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0][TW-1:0] fill_t(input int v);
    for (int i = 0; i < N; i++) fill_t[i] = TW'(v);
  endfunction

  function automatic logic [N-1:0][DW-1:0] fill_d(input int v);
    for (int i = 0; i < N; i++) fill_d[i] = DW'(v);
  endfunction

  function automatic logic [N-1:0][TW-1:0] mk_t(input int e0, e1, e2, e3);
    mk_t = {TW'(e3), TW'(e2), TW'(e1), TW'(e0)};
  endfunction

  function automatic logic [N-1:0][DW-1:0] mk_d(input int e0, e1, e2, e3);
    mk_d = {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  task automatic do_start(input int d);
    init_delay = DW'(d);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns #1 after the edge whose registered ack is visible.
  task automatic send_vec(input string tag,
                          input logic [N-1:0][TW-1:0] t,
                          input logic fin);
    logic ok;
    ok = 1'b0;
    terms_in = t;
    final_scanpoint_in = fin;
    terms_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (terms_ack) begin
        ok = 1'b1;
        break;
      end
    end
    terms_ready = 1'b0;
    check({tag, " terms_ack"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (delays_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, " valid"}, 64'(ok), 64'd1);
  endtask

  task automatic ack_result(input string tag);
    delays_ack = 1'b1;
    tick();
    delays_ack = 1'b0;
    check({tag, " valid drop"}, 64'(delays_valid), 64'd0);
  endtask

  task automatic get_result(input string tag,
                            input logic [N-1:0][DW-1:0] d,
                            input logic lp);
    wait_valid(tag);
    check({tag, " delays"}, 64'(delay_out), 64'(d));
    check({tag, " last_point"}, 64'(last_point), 64'(lp));
    ack_result(tag);
  endtask

  logic seen;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    init_delay = '0;
    terms_in = '0;
    terms_ready = 1'b0;
    final_scanpoint_in = 1'b0;
    delays_ack = 1'b0;
    repeat (3) tick();

    check("rst valid", 64'(delays_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst ack", 64'(terms_ack), 64'd0);
    check("rst last", 64'(last_point), 64'd0);
    check("rst delays", 64'(delay_out), 64'd0);
    rst = 1'b0;
    tick();

    // Scanline A: init 100
    do_start(100);
    check("A busy", 64'(busy), 64'd1);
    send_vec("A1", fill_t(-16), 1'b0);
    tick();
    check("A1 ack pulse", 64'(terms_ack), 64'd0);
    repeat (N - 1) tick();
    check("A1 early valid", 64'(delays_valid), 64'd0);
    tick();
    check("A1 latency", 64'(delays_valid), 64'd1);
    get_result("A1", fill_d(101), 1'b0);

    send_vec("A2", fill_t(48), 1'b0);
    get_result("A2", fill_d(103), 1'b0);

    send_vec("A3", fill_t(48), 1'b0);
    wait_valid("A3");
    check("A3 delays", 64'(delay_out), 64'(fill_d(105)));
    // ack and next ready together: terms taken one edge later
    terms_in = mk_t(-64, 64, 0, -1);
    final_scanpoint_in = 1'b0;
    delays_ack = 1'b1;
    terms_ready = 1'b1;
    tick();
    delays_ack = 1'b0;
    check("A3 valid drop", 64'(delays_valid), 64'd0);
    check("A4 no early ack", 64'(terms_ack), 64'd0);
    tick();
    check("A4 ack", 64'(terms_ack), 64'd1);
    terms_ready = 1'b0;
    get_result("A4", mk_d(106, 107, 107, 107), 1'b0);

    send_vec("A5", fill_t(16), 1'b1);
    get_result("A5", mk_d(107, 109, 109, 108), 1'b1);
    check("A5 idle", 64'(busy), 64'd0);
    terms_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen = seen | terms_ack;
    end
    terms_ready = 1'b0;
    check("idle no ack", 64'(seen), 64'd0);

    // Scanline B: delay saturation
    do_start(4094);
    send_vec("B1", fill_t(48), 1'b0);
    get_result("B1", fill_d(4095), 1'b0);
    send_vec("B2", fill_t(48), 1'b1);
    get_result("B2", fill_d(4095), 1'b1);

    // Scanline C: error accumulator saturates at minimum
    do_start(100);
    for (int s = 1; s <= 6; s++) begin
      send_vec("C", fill_t(-1048576), 1'b0);
      get_result("C", fill_d(100 + s), 1'b0);
    end
    send_vec("C7", fill_t(1048575), 1'b1);
    get_result("C7", fill_d(107), 1'b1);

    // Reset in the middle of PROCESS
    do_start(50);
    send_vec("R", fill_t(16), 1'b0);
    tick();
    tick();
    terms_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("R valid", 64'(delays_valid), 64'd0);
    check("R busy", 64'(busy), 64'd0);
    check("R ack", 64'(terms_ack), 64'd0);
    check("R last", 64'(last_point), 64'd0);
    check("R delays", 64'(delay_out), 64'd0);
    tick();
    check("R pending not acked", 64'(terms_ack), 64'd0);
    terms_ready = 1'b0;

    // start while in WAIT_TERMS is ignored
    do_start(7);
    do_start(999);
    send_vec("S", fill_t(-16), 1'b1);
    get_result("S", fill_d(8), 1'b1);
    check("S idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
